// File: rtl/bus_dma.sv
// bus_dma: copies LEN words SRC->DST as AZPR bus master, programmed via a 4-register slave; BUS_DMA_IRQ_EN adds irq.
// At least 7 cycles per word; stalls without limit on bus_grnt_/bus_rdy_; slave rdy_ pulses one cycle after each access.
module bus_dma #(
    parameter int LEN_W  = 16,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rdy_,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_,
    input  logic              bus_grnt_,
    output logic              bus_req_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wr_data,
    output logic              irq
);
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_SRC  = 2'd1;
    localparam logic [1:0] REG_DST  = 2'd2;
    localparam logic [1:0] REG_LEN  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD_AS,
        S_RD_WAIT,
        S_WR_AS,
        S_WR_WAIT,
        S_GAP
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] src, dst, cur_src, cur_dst;
    logic [LEN_W-1:0]  len, cnt;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] rd_mux;
    logic              done, irq_en, busy;
    logic              acc, reg_wr, start, load, hw_done;
    logic              unused_bits;

    assign acc     = !cs_ && !as_;
    assign reg_wr  = acc && (rw == WRITE);
    assign busy    = (state != S_IDLE);
    assign start   = reg_wr && (addr == REG_CTRL) && wr_data[0] && !busy;
    assign load    = start && (len != '0);
    assign hw_done = (start && (len == '0)) || ((state == S_GAP) && (cnt == '0));

    assign bus_wr_data = word;
    assign unused_bits = ^{wr_data[DATA_W-1:ADDR_W], wr_data[2]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // bus_req_ is held low from REQ through WR_WAIT so the arbiter cannot
    // hand the bus away between the read and the write of one word.
    always_comb begin
        state_nxt = state;
        bus_req_  = 1'b1;
        bus_as_   = 1'b1;
        bus_rw    = READ;
        bus_addr  = '0;
        case (state)
            S_IDLE: begin
                if (load) state_nxt = S_REQ;
            end
            S_REQ: begin
                bus_req_ = 1'b0;
                if (!bus_grnt_) state_nxt = S_RD_AS;
            end
            S_RD_AS: begin
                bus_req_  = 1'b0;
                bus_as_   = 1'b0;
                bus_addr  = cur_src;
                state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                bus_req_ = 1'b0;
                bus_addr = cur_src;
                if (!bus_rdy_) state_nxt = S_WR_AS;
            end
            S_WR_AS: begin
                bus_req_  = 1'b0;
                bus_as_   = 1'b0;
                bus_rw    = WRITE;
                bus_addr  = cur_dst;
                state_nxt = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                bus_req_ = 1'b0;
                bus_rw   = WRITE;
                bus_addr = cur_dst;
                if (!bus_rdy_) state_nxt = S_GAP;
            end
            S_GAP: begin
                state_nxt = (cnt == '0) ? S_IDLE : S_REQ;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src     <= '0;
            dst     <= '0;
            len     <= '0;
            cnt     <= '0;
            cur_src <= '0;
            cur_dst <= '0;
            word    <= '0;
            done    <= 1'b0;
        end else begin
            if (reg_wr && !busy) begin
                case (addr)
                    REG_SRC: src <= wr_data[ADDR_W-1:0];
                    REG_DST: dst <= wr_data[ADDR_W-1:0];
                    REG_LEN: len <= wr_data[LEN_W-1:0];
                    default: ;
                endcase
            end
            // Hardware set is ordered last so it wins over a same-cycle clear.
            if (reg_wr && (addr == REG_CTRL) && wr_data[1]) done <= 1'b0;
            if (hw_done) done <= 1'b1;
            if (load) begin
                cnt     <= len;
                cur_src <= src;
                cur_dst <= dst;
            end
            if ((state == S_RD_WAIT) && !bus_rdy_) word <= bus_rd_data;
            if ((state == S_WR_WAIT) && !bus_rdy_) begin
                cnt     <= cnt - LEN_W'(1);
                cur_src <= cur_src + ADDR_W'(1);
                cur_dst <= cur_dst + ADDR_W'(1);
            end
        end
    end

`ifdef BUS_DMA_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en <= 1'b0;
        end else if (reg_wr && (addr == REG_CTRL)) begin
            irq_en <= wr_data[2];
        end
    end

    assign irq = done & irq_en;
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (addr)
            REG_CTRL: rd_mux = {{(DATA_W-3){1'b0}}, irq_en, done, busy};
            REG_SRC:  rd_mux = {{(DATA_W-ADDR_W){1'b0}}, src};
            REG_DST:  rd_mux = {{(DATA_W-ADDR_W){1'b0}}, dst};
            REG_LEN:  rd_mux = {{(DATA_W-LEN_W){1'b0}}, len};
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_    <= 1'b1;
            rd_data <= '0;
        end else begin
            rdy_    <= !acc;
            rd_data <= (acc && (rw == READ)) ? rd_mux : '0;
        end
    end
endmodule

// File: tb/tb_bus_dma.sv
// Directed bench for bus_dma with a bus slave/arbiter model (registered grant, programmable wait states).
module tb_bus_dma;
    logic        clk = 1'b0;
    logic        reset;
    logic        cs_, as_, rw;
    logic [1:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rdy_;
    logic [31:0] bus_rd_data = '0;
    logic        bus_rdy_ = 1'b1;
    logic        bus_grnt_ = 1'b1;
    logic        bus_req_;
    logic [29:0] bus_addr;
    logic        bus_as_;
    logic        bus_rw;
    logic [31:0] bus_wr_data;
    logic        irq;

    logic        hold_grnt;
    int          slave_waits;
    int          total = 0;
    int          bad = 0;

    bus_dma dut (
        .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_),
        .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_), .bus_grnt_(bus_grnt_),
        .bus_req_(bus_req_), .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw),
        .bus_wr_data(bus_wr_data), .irq(irq)
    );

    always #5 clk = ~clk;

    // Bus model: every address phase is logged; a read returns the last word
    // written to that address, or {2'b11, addr} if it was never written.
    logic [29:0] log_addr[$];
    logic        log_rw[$];
    logic [31:0] log_dat[$];
    logic        pend = 1'b0;
    logic        pend_rw = 1'b1;
    logic [29:0] pend_addr = '0;
    int          wcnt = 0;
    int          req_low_cycles = 0;
    int          stab_err = 0;
    logic        go;
    logic [29:0] g_addr;
    logic        g_rw;

    function automatic logic [31:0] mem_rd(input logic [29:0] a);
        for (int i = log_addr.size() - 1; i >= 0; i--)
            if (!log_rw[i] && log_addr[i] == a) return log_dat[i];
        return {2'b11, a};
    endfunction

    function automatic logic [31:0] log_ent(input int idx);
        if (idx >= log_addr.size()) return 32'hFFFF_FFFF;
        return {1'b0, log_rw[idx], log_addr[idx]};
    endfunction

    always_comb begin
        go     = 1'b0;
        g_addr = bus_addr;
        g_rw   = bus_rw;
        if (!bus_as_) begin
            go = (slave_waits == 0);
        end else if (pend && wcnt == 0) begin
            go     = 1'b1;
            g_addr = pend_addr;
            g_rw   = pend_rw;
        end
    end

    always @(posedge clk) begin
        bus_rdy_  <= 1'b1;
        bus_grnt_ <= (reset || hold_grnt) ? 1'b1 : bus_req_;
        if (!bus_req_) req_low_cycles <= req_low_cycles + 1;
        if (!bus_as_) begin
            log_addr.push_back(bus_addr);
            log_rw.push_back(bus_rw);
            log_dat.push_back(bus_wr_data);
            pend      <= (slave_waits != 0);
            pend_rw   <= bus_rw;
            pend_addr <= bus_addr;
            wcnt      <= (slave_waits != 0) ? slave_waits - 1 : 0;
        end else if (pend) begin
            if (!bus_req_ && (bus_addr !== pend_addr || bus_rw !== pend_rw))
                stab_err <= stab_err + 1;
            if (wcnt == 0) pend <= 1'b0;
            else wcnt <= wcnt - 1;
        end
        if (go) begin
            bus_rdy_ <= 1'b0;
            if (g_rw) bus_rd_data <= mem_rd(g_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = a; wr_data = d;
        @(negedge clk);
        cs_ = 1'b1; as_ = 1'b1; rw = 1'b1;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = a;
        @(negedge clk);
        cs_ = 1'b1; as_ = 1'b1;
        d = rd_data;
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] v;
        logic        ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            reg_read(2'd0, v);
            if (v[0] == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_finish"}, {31'b0, ok}, 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        int          base, req0, stab0, n;
        logic        found;

        reset = 1'b1; cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = 2'd0; wr_data = '0;
        hold_grnt = 1'b0; slave_waits = 0;
        @(negedge clk);
        check("rst_rdy", {31'b0, rdy_}, 32'd1);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_bus_req", {31'b0, bus_req_}, 32'd1);
        check("rst_bus_as", {31'b0, bus_as_}, 32'd1);
        check("rst_bus_rw", {31'b0, bus_rw}, 32'd1);
        check("rst_bus_addr", {2'b0, bus_addr}, 32'd0);
        check("rst_bus_wr_data", bus_wr_data, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 1: three-word copy
        reg_write(2'd3, 32'd3);
        reg_write(2'd1, 32'h100);
        reg_write(2'd2, 32'h200);
        reg_read(2'd1, v);
        check("t1_src_rd", v, 32'h100);
        check("t1_rdy_low", {31'b0, rdy_}, 32'd0);
        @(negedge clk);
        check("t1_rdy_high", {31'b0, rdy_}, 32'd1);
        base = log_addr.size();
        reg_write(2'd0, 32'h1);
        wait_done("t1");
        check("t1_nxfer", log_addr.size() - base, 32'd6);
        check("t1_x0", log_ent(base + 0), 32'h4000_0100);
        check("t1_x1", log_ent(base + 1), 32'h0000_0200);
        check("t1_x2", log_ent(base + 2), 32'h4000_0101);
        check("t1_x3", log_ent(base + 3), 32'h0000_0201);
        check("t1_x4", log_ent(base + 4), 32'h4000_0102);
        check("t1_x5", log_ent(base + 5), 32'h0000_0202);
        check("t1_mem200", mem_rd(30'h200), 32'hC000_0100);
        check("t1_mem202", mem_rd(30'h202), 32'hC000_0102);
        reg_read(2'd0, v);
        check("t1_ctrl", v, 32'h2);
        reg_read(2'd3, v);
        check("t1_len_kept", v, 32'd3);

        // 2: LEN=0 start
        reg_write(2'd0, 32'h2);
        reg_read(2'd0, v);
        check("t2_done_clr", v, 32'h0);
        reg_write(2'd3, 32'd0);
        req0 = req_low_cycles;
        base = log_addr.size();
        reg_write(2'd0, 32'h1);
        reg_read(2'd0, v);
        check("t2_ctrl", v, 32'h2);
        repeat (5) @(negedge clk);
        check("t2_no_req", req_low_cycles - req0, 32'd0);
        check("t2_no_xfer", log_addr.size() - base, 32'd0);

        // 3: grant withheld, slow slave, register write while busy
        reg_write(2'd0, 32'h2);
        hold_grnt = 1'b1;
        slave_waits = 3;
        reg_write(2'd3, 32'd1);
        reg_write(2'd1, 32'h300);
        reg_write(2'd2, 32'h310);
        base = log_addr.size();
        stab0 = stab_err;
        reg_write(2'd0, 32'h1);
        reg_write(2'd1, 32'h999);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (!bus_req_ && bus_as_) n++;
            @(negedge clk);
        end
        check("t3_req_held", n, 32'd10);
        hold_grnt = 1'b0;
        wait_done("t3");
        check("t3_stable", stab_err - stab0, 32'd0);
        check("t3_x0", log_ent(base + 0), 32'h4000_0300);
        check("t3_x1", log_ent(base + 1), 32'h0000_0310);
        check("t3_data", mem_rd(30'h310), 32'hC000_0300);
        reg_read(2'd1, v);
        check("t3_src_ignored", v, 32'h300);

        // 4: source address wrap
        slave_waits = 0;
        reg_write(2'd0, 32'h2);
        reg_write(2'd1, 32'h3FFF_FFFF);
        reg_write(2'd2, 32'h400);
        reg_write(2'd3, 32'd2);
        base = log_addr.size();
        reg_write(2'd0, 32'h1);
        wait_done("t4");
        check("t4_x0", log_ent(base + 0), 32'h7FFF_FFFF);
        check("t4_x1", log_ent(base + 1), 32'h0000_0400);
        check("t4_x2", log_ent(base + 2), 32'h4000_0000);
        check("t4_x3", log_ent(base + 3), 32'h0000_0401);
        check("t4_mem401", mem_rd(30'h401), 32'hC000_0000);
        reg_read(2'd1, v);
        check("t4_src_kept", v, 32'h3FFF_FFFF);

        // 5: reset during RD_WAIT
        slave_waits = 3;
        reg_write(2'd0, 32'h2);
        reg_write(2'd1, 32'h500);
        reg_write(2'd2, 32'h600);
        reg_write(2'd3, 32'd5);
        reg_write(2'd0, 32'h1);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!bus_as_ && bus_rw) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t5_rd_as_seen", {31'b0, found}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_req", {31'b0, bus_req_}, 32'd1);
        check("t5_as", {31'b0, bus_as_}, 32'd1);
        reset = 1'b0;
        slave_waits = 0;
        reg_read(2'd0, v);
        check("t5_ctrl", v, 32'h0);
        reg_read(2'd3, v);
        check("t5_len", v, 32'h0);
        repeat (8) @(negedge clk);

        // 6: interrupt
        reg_write(2'd0, 32'h4);
        reg_write(2'd3, 32'd1);
        reg_write(2'd1, 32'h700);
        reg_write(2'd2, 32'h710);
`ifdef BUS_DMA_IRQ_EN
        reg_read(2'd0, v);
        check("t6_irq_en", v, 32'h4);
        reg_write(2'd0, 32'h5);
        wait_done("t6");
        check("t6_irq_set", {31'b0, irq}, 32'd1);
        reg_read(2'd0, v);
        check("t6_ctrl", v, 32'h6);
        reg_write(2'd0, 32'h6);
        check("t6_irq_clr", {31'b0, irq}, 32'd0);
`else
        reg_read(2'd0, v);
        check("t6_irq_en_absent", v, 32'h0);
        reg_write(2'd0, 32'h5);
        wait_done("t6");
        check("t6_irq_tied", {31'b0, irq}, 32'd0);
        reg_read(2'd0, v);
        check("t6_ctrl", v, 32'h2);
`endif
        check("t6_data", mem_rd(30'h710), 32'hC000_0700);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
